// File: rtl/axi4lite_reg_bridge_pkg.sv
// Shared response codes, FSM state encoding and timeout counter width for axi4lite_reg_bridge.
package axi4lite_reg_bridge_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam int unsigned TimeoutW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } state_e;

endpackage

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave bridging single-beat transactions onto a request/ack register bus.
// Optional request timeout enabled by defining AXI4LITE_BRIDGE_TIMEOUT_EN.
module axi4lite_reg_bridge
  import axi4lite_reg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  input  logic [31:0] inport_awaddr_i,
  input  logic        inport_wvalid_i,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  input  logic        inport_bready_i,
  input  logic        inport_arvalid_i,
  input  logic [31:0] inport_araddr_i,
  input  logic        inport_rready_i,
  output logic        inport_awready_o,
  output logic        inport_wready_o,
  output logic        inport_bvalid_o,
  output logic [1:0]  inport_bresp_o,
  output logic        inport_arready_o,
  output logic        inport_rvalid_o,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [31:0] outport_addr_o,
  output logic [31:0] outport_data_wr_o,
  output logic [3:0]  outport_wr_o,
  output logic        outport_rd_o,
  input  logic        outport_accept_i,
  input  logic        outport_ack_i,
  input  logic        outport_error_i,
  input  logic [31:0] outport_data_rd_i
);

  state_e      state_q, state_d;
  logic        prio_rd_q, prio_rd_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_elig;
  logic grant_wr;
  logic grant_rd;
  logic timeout;

  // Byte offset within the word is dropped on the register bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{inport_awaddr_i[1:0], inport_araddr_i[1:0]};

`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
  localparam logic [TimeoutW-1:0] TimeoutLimit = TimeoutW'(TIMEOUT_CYCLES);

  logic [TimeoutW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                busy;

  assign busy = (state_q == StReq) || (state_q == StWait);

  // REQ is only ever entered from IDLE, so clearing in IDLE starts each request at zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StIdle) begin
      tmo_cnt_d = '0;
    end else if (busy) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign timeout = busy && (TimeoutW'(tmo_cnt_q + 1'b1) == TimeoutLimit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    wr_elig  = inport_awvalid_i & inport_wvalid_i;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle) begin
      if (wr_elig && inport_arvalid_i) begin
        grant_rd = prio_rd_q;
        grant_wr = ~prio_rd_q;
      end else begin
        grant_wr = wr_elig;
        grant_rd = inport_arvalid_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          prio_rd_d = ~prio_rd_q;
          is_wr_d   = 1'b1;
          addr_d    = {inport_awaddr_i[31:2], 2'b00};
          wdata_d   = inport_wdata_i;
          strb_d    = inport_wstrb_i;
          resp_d    = RespOkay;
          rdata_d   = '0;
          // An all-zero strobe write has nothing to tell the peripheral.
          state_d   = (inport_wstrb_i == 4'h0) ? StResp : StReq;
        end else if (grant_rd) begin
          prio_rd_d = ~prio_rd_q;
          is_wr_d   = 1'b0;
          addr_d    = {inport_araddr_i[31:2], 2'b00};
          wdata_d   = '0;
          strb_d    = '0;
          resp_d    = RespOkay;
          rdata_d   = '0;
          state_d   = StReq;
        end
      end
      StReq, StWait: begin
        if (outport_ack_i && (outport_accept_i || (state_q == StWait))) begin
          resp_d  = outport_error_i ? RespSlvErr : RespOkay;
          rdata_d = is_wr_q ? '0 : outport_data_rd_i;
          state_d = StResp;
        end else if (timeout) begin
          resp_d  = RespSlvErr;
          rdata_d = '0;
          state_d = StResp;
        end else if (outport_accept_i && (state_q == StReq)) begin
          state_d = StWait;
        end
      end
      StResp: begin
        if ((is_wr_q && inport_bready_i) || (!is_wr_q && inport_rready_i)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      prio_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      resp_q  <= RespOkay;
      rdata_q <= '0;
    end else begin
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign inport_awready_o  = grant_wr;
  assign inport_wready_o   = grant_wr;
  assign inport_arready_o  = grant_rd;

  assign inport_bvalid_o   = (state_q == StResp) && is_wr_q;
  assign inport_rvalid_o   = (state_q == StResp) && !is_wr_q;
  assign inport_bresp_o    = inport_bvalid_o ? resp_q : RespOkay;
  assign inport_rresp_o    = inport_rvalid_o ? resp_q : RespOkay;
  assign inport_rdata_o    = inport_rvalid_o ? rdata_q : '0;

  assign outport_addr_o    = addr_q;
  assign outport_data_wr_o = wdata_q;
  assign outport_wr_o      = ((state_q == StReq) && is_wr_q) ? strb_q : 4'h0;
  assign outport_rd_o      = (state_q == StReq) && !is_wr_q;

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Self-checking bench for axi4lite_reg_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_axi4lite_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_wr;
  logic        o_rd;
  logic        accept, ack, error;
  logic [31:0] data_rd;

  int checks   = 0;
  int failures = 0;
  bit prio_rd;  // model: read wins the next contested grant

  always #5 clk = ~clk;

  axi4lite_reg_bridge #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .inport_awvalid_i  (awvalid),
    .inport_awaddr_i   (awaddr),
    .inport_wvalid_i   (wvalid),
    .inport_wdata_i    (wdata),
    .inport_wstrb_i    (wstrb),
    .inport_bready_i   (bready),
    .inport_arvalid_i  (arvalid),
    .inport_araddr_i   (araddr),
    .inport_rready_i   (rready),
    .inport_awready_o  (awready),
    .inport_wready_o   (wready),
    .inport_bvalid_o   (bvalid),
    .inport_bresp_o    (bresp),
    .inport_arready_o  (arready),
    .inport_rvalid_o   (rvalid),
    .inport_rdata_o    (rdata),
    .inport_rresp_o    (rresp),
    .outport_addr_o    (o_addr),
    .outport_data_wr_o (o_wdata),
    .outport_wr_o      (o_wr),
    .outport_rd_o      (o_rd),
    .outport_accept_i  (accept),
    .outport_ack_i     (ack),
    .outport_error_i   (error),
    .outport_data_rd_i (data_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a single-channel request to an idle bridge and complete the address handshake.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    if (wr) begin
      awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
    end else begin
      arvalid = 1'b1; araddr = addr;
    end
    #1;
    chk(wr ? "awready" : "arready", wr ? awready : arready, 1);
    chk("other_ready", wr ? arready : awready, 0);
    chk("wready_eq_awready", wready, awready);
    prio_rd = !prio_rd;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  // Play the peripheral and the response side for a transaction whose address phase just finished.
  task automatic serve(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int acc_dly, input int ack_dly,
                       input bit err, input logic [31:0] rd_val, input int rdy_dly,
                       input bit poke);
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    exp_resp  = 2'b00;
    exp_rdata = 32'h0;
    if (!(wr && strb == 4'h0)) begin
      #1;
      chk("req_addr", o_addr, {addr[31:2], 2'b00});
      chk("req_wr", o_wr, wr ? strb : 4'h0);
      chk("req_rd", o_rd, !wr);
      if (wr) chk("req_wdata", o_wdata, data);
      chk("busy_no_ready", {awready, wready, arready}, 0);
      for (int i = 0; i < acc_dly; i++) begin
        step();
        #1;
        chk("req_hold_wr", o_wr, wr ? strb : 4'h0);
        chk("req_hold_rd", o_rd, !wr);
      end
      accept = 1'b1;
      if (ack_dly == 0) begin
        ack = 1'b1; error = err; data_rd = rd_val;
      end
      step();
      accept = 1'b0; ack = 1'b0; error = 1'b0; data_rd = $urandom;
      if (ack_dly > 0) begin
        for (int i = 1; i < ack_dly; i++) begin
          #1;
          chk("wait_no_req", {o_wr, o_rd}, 0);
          chk("wait_no_resp", bvalid | rvalid, 0);
          step();
        end
        ack = 1'b1; error = err; data_rd = rd_val;
        step();
        ack = 1'b0; error = 1'b0; data_rd = $urandom;
      end
      exp_resp  = err ? 2'b10 : 2'b00;
      exp_rdata = wr ? 32'h0 : rd_val;
    end
    #1;
    chk(wr ? "bvalid" : "rvalid", wr ? bvalid : rvalid, 1);
    chk("other_valid", wr ? rvalid : bvalid, 0);
    if (wr) begin
      chk("bresp", bresp, exp_resp);
    end else begin
      chk("rresp", rresp, exp_resp);
      chk("rdata", rdata, exp_rdata);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      if (poke) begin
        awvalid = 1'b1; awaddr = $urandom; wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
        arvalid = 1'b1; araddr = $urandom;
      end
      step();
      chk("hold_valid", wr ? bvalid : rvalid, 1);
      chk("hold_resp", wr ? bresp : rresp, exp_resp);
      if (!wr) chk("hold_rdata", rdata, exp_rdata);
      chk("hold_no_ready", {awready, wready, arready}, 0);
    end
    if (poke) begin
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    end
    if (wr) bready = 1'b1; else rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    #1;
    chk("resp_done", bvalid | rvalid, 0);
  endtask

  // Write and read both eligible in IDLE: the model's priority flag picks the winner.
  task automatic contend();
    logic [31:0] wa, wd, ra, rv1, rv2;
    logic [3:0]  ws;
    bit          rd_first;
    wa = $urandom; wd = $urandom; ra = $urandom; rv1 = $urandom; rv2 = $urandom;
    ws = 4'($urandom_range(1, 15));
    awvalid = 1'b1; awaddr = wa; wvalid = 1'b1; wdata = wd; wstrb = ws;
    arvalid = 1'b1; araddr = ra;
    rd_first = prio_rd;
    #1;
    chk("arb_arready", arready, rd_first);
    chk("arb_awready", awready, !rd_first);
    chk("arb_wready", wready, !rd_first);
    prio_rd = !prio_rd;
    step();
    if (rd_first) begin
      arvalid = 1'b0;
      serve(0, ra, 0, 0, 0, 0, 0, rv1, 0, 0);
      issue(1, wa, wd, ws);
      serve(1, wa, wd, ws, 0, 0, 0, rv2, 0, 0);
    end else begin
      awvalid = 1'b0; wvalid = 1'b0;
      serve(1, wa, wd, ws, 0, 0, 0, rv1, 0, 0);
      issue(0, ra, 0, 0);
      serve(0, ra, 0, 0, 0, 0, 0, rv2, 0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] a, d, rv;
    logic [3:0]  s;
    bit          wr;

    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    accept = 1'b0; ack = 1'b0; error = 1'b0; data_rd = '0;
    repeat (3) step();
    rst = 1'b0;
    prio_rd = 1'b1;
    #1;
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_outport_wr", o_wr, 0);
    chk("rst_outport_rd", o_rd, 0);
    chk("rst_outport_addr", o_addr, 0);
    chk("rst_outport_data", o_wdata, 0);
    chk("rst_readies", {awready, wready, arready}, 0);

    // Minimum-latency write: accept and ack in the first request cycle.
    issue(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    serve(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, 0, 0);

    // Read acked three cycles after accept.
    issue(0, 32'h0000_2004, 32'h0, 4'h0);
    serve(0, 32'h0000_2004, 32'h0, 4'h0, 0, 3, 0, 32'h1234_5678, 0, 0);

    repeat (4) contend();

    // Address valid without write data must not be accepted.
    a = 32'h0000_3008; d = $urandom;
    awvalid = 1'b1; awaddr = a;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("aw_only_awready", awready, 0);
      chk("aw_only_wready", wready, 0);
      step();
    end
    issue(1, a, d, 4'h3);
    serve(1, a, d, 4'h3, 1, 0, 0, 32'h0, 0, 0);

    // Error read with a stalled master and fresh requests knocking during the stall.
    issue(0, 32'h0000_4000, 32'h0, 4'h0);
    serve(0, 32'h0000_4000, 32'h0, 4'h0, 1, 2, 1, 32'hCAFE_F00D, 10, 1);

    // Zero-strobe write responds OKAY without a register-bus request.
    issue(1, 32'h0000_5000, 32'h5555_AAAA, 4'h0);
    serve(1, 32'h0000_5000, 32'h5555_AAAA, 4'h0, 0, 0, 1, 32'h0, 1, 0);

    // Reset during WAIT abandons the read; a stray ack afterwards must not produce a response.
    issue(0, 32'h0000_6000, 32'h0, 4'h0);
    #1;
    chk("abort_req_rd", o_rd, 1);
    accept = 1'b1;
    step();
    accept = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    prio_rd = 1'b1;
    #1;
    chk("abort_rvalid", rvalid, 0);
    chk("abort_outport_rd", o_rd, 0);
    chk("abort_outport_addr", o_addr, 0);
    ack = 1'b1; data_rd = 32'hBAD0_BAD0;
    step();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_resp", {bvalid, rvalid}, 0);
      step();
    end
    contend();

`ifdef AXI4LITE_BRIDGE_TIMEOUT_EN
    issue(0, 32'h0000_7000, 32'h0, 4'h0);
    accept = 1'b1;
    step();
    accept = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("tmo_pending", rvalid, 0);
      step();
    end
    chk("tmo_rvalid", rvalid, 1);
    chk("tmo_rresp", rresp, 2'b10);
    chk("tmo_rdata", rdata, 0);
    ack = 1'b1; data_rd = 32'hFFFF_FFFF;
    step();
    ack = 1'b0;
    chk("tmo_stray_ack", rdata, 0);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("tmo_done", rvalid, 0);
`endif

    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      rv = $urandom;
      s  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(wr, a, d, s);
      serve(wr, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), rv, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
